// File: rtl/disp_pkg.sv
// Shared types and constants for the scanned seven-segment debug display.
package disp_pkg;

    // Each digit slot starts blanked, then drives the selected anode.
    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    // Everything off on a common-anode display is all ones.
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] EN_OFF  = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns, indexed by hex value (entry 0 is rightmost).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder with a blank override.
module hex_to_seg7
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank wins over the table lookup so leading-zero suppression can reuse this decoder.
    always_comb begin
        seg = SEG_TABLE[nibble];
        if (blank) begin
            seg = SEG_OFF;
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 8-digit common-anode display of two 16-bit debug words.
// Words are latched into shadow registers on a synchronized Update edge so the
// shown values stay stable while the slower pipeline clock keeps running.
module seg_scan_display
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000,
    parameter bit LZ_BLANK     = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] DataA,
    input  logic [15:0] DataB,
    input  logic        Update,
    input  logic        Hold,
    output logic [6:0]  out7,
    output logic [7:0]  en_out
);

    localparam int            CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_DRIVE = CW'(BLANK_CYCLES);

    // Update synchronizer; sync3 holds the previous synchronized level for edge detection.
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sync3_q, sync3_d;
    logic upd_edge;

    logic [15:0] shadow_a_q, shadow_a_d;
    logic [15:0] shadow_b_q, shadow_b_d;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    scan_state_e   state_q, state_d;

    logic [6:0] out7_q, out7_d;
    logic [7:0] en_q, en_d;

    // Per-digit nibble and "this digit plus all higher ones in its group are zero".
    logic [3:0] nib_w [8];
    logic [7:0] lz_w;
    logic [3:0] cur_nib;
    logic       cur_blank;
    logic [6:0] seg_w;

    // Map each digit onto its shadow nibble; digits 0..3 come from B, 4..7 from A.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            localparam int POS = gi % 4;
            logic [15:0] grp_w;
            if (gi < 4) begin : g_lo
                assign grp_w = shadow_b_q;
            end else begin : g_hi
                assign grp_w = shadow_a_q;
            end
            assign nib_w[gi] = grp_w[4*POS +: 4];
            // The lowest digit of each group always shows, even when zero.
            assign lz_w[gi]  = (POS != 0) && ((grp_w >> (4*POS)) == 16'd0);
        end
    endgenerate

    // Update edge detect and shadow load; a held Update level gives only one load.
    always_comb begin
        sync1_d    = Update;
        sync2_d    = sync1_q;
        sync3_d    = sync2_q;
        upd_edge   = sync2_q & ~sync3_q;
        shadow_a_d = shadow_a_q;
        shadow_b_d = shadow_b_q;
        if (upd_edge && !Hold) begin
            shadow_a_d = DataA;
            shadow_b_d = DataB;
        end
    end

    // Slot counter, digit index and scan state; state follows the counter position.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
        state_d = (cnt_d < CNT_DRIVE) ? BLANK : DRIVE;
    end

    // Select the digit being scanned and decide whether it is suppressed.
    always_comb begin
        cur_nib   = nib_w[idx_q];
        cur_blank = LZ_BLANK && lz_w[idx_q];
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (cur_nib),
        .blank  (cur_blank),
        .seg    (seg_w)
    );

    // Output drive: all anodes off while blanking, otherwise exactly one anode low.
    always_comb begin
        en_d   = EN_OFF;
        out7_d = SEG_OFF;
        if (state_q == DRIVE) begin
            en_d   = ~(8'd1 << idx_q);
            out7_d = seg_w;
        end
    end

    // Synchronizer and shadow registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            shadow_a_q <= '0;
            shadow_b_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync3_q    <= sync3_d;
            shadow_a_q <= shadow_a_d;
            shadow_b_q <= shadow_b_d;
        end
    end

    // Scan state register plus registered outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= BLANK;
            out7_q  <= SEG_OFF;
            en_q    <= EN_OFF;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            out7_q  <= out7_d;
            en_q    <= en_d;
        end
    end

    assign out7   = out7_q;
    assign en_out = en_q;

endmodule
